float_unit: RTL and testbench
=============================

# float_unit

Multi-cycle IEEE-754-style floating-point unit for `BITS`-wide operands: multiply, divide, add and subtract with round-to-nearest-even, special-value handling and exception flags. It is the next-generation scalar float core for the arithmetic library and is driven by a start/ready handshake. Compared with the plain float operator it adds:
- operand latching
- iterative division
- single-cycle normalisation, giving fixed latencies
- full NaN/Inf/zero handling

## Interface
- `BITS`, 32, total word width
- `EXP_BITS`, 8, exponent width
- `MANT_BITS`, `BITS-EXP_BITS-1`, stored mantissa width (hidden bit implicit)
- `EXP_BIAS`, `2^(EXP_BITS-1)-1`, exponent bias
- `in_clk`  in  1  clock; single clock domain
- `in_rst`  in  1  reset, synchronous, active-high
- `in_start`  in  1  start request; accepted only while `out_ready`=1
- `in_a`, `in_b`  in  `BITS`  operands; sampled on the accepting edge
- `in_op`  in  2  operation: 00 mul, 01 div, 10 add, 11 sub (a-b)
- `out_result`  out  `BITS`  result; held from Done until the next accepted start
- `out_flags`  out  5  {invalid, div_by_zero, overflow, underflow, inexact}; same lifetime as `out_result`
- `out_ready`  out  1  high in Idle only
- `out_valid`  out  1  one-cycle pulse in Done

## Operation
- States: Idle, Unpack, Mult, Div, Align, AddSub, Norm, Round, Done.
- Idle -> Unpack on `in_start`. Operands and op are latched; `out_result`/`out_flags` are not cleared.
- Unpack:
  - Split each operand into sign, exponent, and mantissa with hidden bit.
  - Exponent 0 means zero: subnormal inputs are flushed to zero.
  - Exponent all-ones means Inf (mantissa 0) or NaN.
  - Sub inverts b's sign and proceeds as add.
  - Special cases go directly to Done:
    - Any NaN input gives canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0), no flags.
    - invalid -> qNaN: 0*Inf, Inf-Inf (effective), 0/0, Inf/Inf.
    - Finite nonzero / 0 gives signed Inf with div_by_zero.
    - Inf operands otherwise give correctly signed Inf or zero.
    - Zero operands give signed zero.
    - Add of zeros gives -0 only if both are -0.
  - Otherwise go to Mult, Div or Align.
- Mult: exponent = ea+eb-bias. Full (`MANT_BITS`+1)² product is reduced to `MANT_BITS`+1 bits plus guard, round and sticky.
- Div:
  - Restoring division, one quotient bit per cycle, `MANT_BITS`+3 cycles.
  - Exponent = ea-eb+bias.
  - Sticky = remainder≠0.
- Align: smaller-exponent mantissa shifted right by the exponent difference into guard/round/sticky. A difference > `MANT_BITS`+2 leaves sticky only.
- AddSub:
  - Same effective sign: add.
  - Otherwise subtract smaller magnitude from larger; sign of the larger.
  - Exact zero result is +0, no flags.
- Norm:
  - One cycle.
  - Carry-out: shift right 1, exp+1.
  - Else leading-zero count: shift left, exp-lzc.
- Round:
  - Nearest-even on guard/round/sticky; inexact = any of the three set.
  - Mantissa carry from rounding gives exp+1, mantissa 0.
- Exponent range:
  - Exponent arithmetic uses signed `EXP_BITS`+2 bits internally.
  - Exp ≥ all-ones gives ±Inf with overflow and inexact.
  - Exp ≤ 0 gives signed zero with underflow and inexact.
- Done: drive result/flags, pulse `out_valid`, -> Idle.
- `in_start` while busy is ignored; inputs may change freely after acceptance.
- Reset (any state, including mid-Div):
  - next edge: Idle
  - `out_result`=0, `out_flags`=0, `out_valid`=0, `out_ready`=1
  - internal registers cleared

## Timing
- Latency L = rising edges from the accepting edge (inclusive) until `out_valid`=1:
  - special cases: 2
  - mul: 5
  - add/sub: 6
  - div: `MANT_BITS`+7 (30 for 32-bit)
- `out_ready` drops the cycle after acceptance and returns the cycle after Done.
- Earliest next start is therefore L+1 edges after the previous one.

## Test plan
- Mul 0x3FC00000 × 0x40000000 (1.5×2) -> 0x40400000, flags 0, `out_valid` at L=5.
- Div 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, inexact=1, L=30.
- Add:
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1, L=6.
  - Sub 0x3F800000 - 0x3F800000 -> 0x00000000, flags 0.
- Specials:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid, L=2.
  - 0x3F800000 / 0 -> 0x7F800000, div_by_zero.
  - 0x7F7FFFFF × 0x40000000 -> 0x7F800000, overflow+inexact.
  - 0x00800000 × 0x3F000000 -> 0x00000000, underflow+inexact.
- Handshake/reset:
  - `in_start` pulses during a Div are ignored.
  - `in_rst` asserted in Div cycle 10 -> next edge `out_ready`=1, `out_result`=0, no `out_valid`.
  - A following mul completes normally.

Source files
------------

// File: rtl/float_unit.sv
// rtl/float_unit.sv - multi-cycle float unit: mul, div, add, sub with round-to-nearest-even
module float_unit #(
  parameter int BITS      = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = BITS - EXP_BITS - 1,
  parameter int EXP_BIAS  = (1 << (EXP_BITS - 1)) - 1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  input  logic [1:0]      in_op,
  output logic [BITS-1:0] out_result,
  output logic [4:0]      out_flags,
  output logic            out_ready,
  output logic            out_valid
);
  // Working significand: carry, hidden bit, MANT_BITS fraction, guard, round, sticky.
  localparam int SW = MANT_BITS + 5;
  localparam int XW = EXP_BITS + 2;
  localparam int CW = $clog2(MANT_BITS + 3);
  localparam logic signed [XW-1:0] BIAS_X    = XW'(EXP_BIAS);
  localparam logic signed [XW-1:0] BIAS_M1_X = XW'(EXP_BIAS - 1);
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX_X = XW'((1 << EXP_BITS) - 1);
  localparam logic [EXP_BITS-1:0] DIFF_LIM   = EXP_BITS'(MANT_BITS + 4);
  localparam logic [CW-1:0]       DIV_LAST   = CW'(MANT_BITS + 2);
  localparam logic [CW-1:0]       ONE_C      = CW'(1);
  localparam logic [4:0] F_INV = 5'b10000, F_DBZ = 5'b01000, F_OVF = 5'b00101, F_UNF = 5'b00011;
  localparam logic [BITS-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_MULT, S_DIV, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [BITS-1:0]       a_q, b_q;
  logic [1:0]            op_q;
  logic                  sign_q, eff_sub_q;
  logic signed [XW-1:0]  exp_q;
  logic [MANT_BITS:0]    ma_q, mb_q;
  logic [MANT_BITS+1:0]  rem_q;
  logic [MANT_BITS+3:0]  x_q, y_q;
  logic [EXP_BITS-1:0]   diff_q;
  logic [SW-1:0]         sig_q;
  logic [CW-1:0]         cnt_q;

  function automatic logic [BITS-1:0] f_inf(input logic s);
    return {s, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
  endfunction
  function automatic logic [BITS-1:0] f_zero(input logic s);
    return {s, {(BITS-1){1'b0}}};
  endfunction

  // Operand fields of the latched words
  logic [EXP_BITS-1:0]  ea, eb;
  logic [MANT_BITS:0]   ma, mb;
  logic signed [XW-1:0] ea_x, eb_x;
  logic sa, sb, sbe, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  assign ea     = a_q[BITS-2:MANT_BITS];
  assign eb     = b_q[BITS-2:MANT_BITS];
  assign ma     = {1'b1, a_q[MANT_BITS-1:0]};
  assign mb     = {1'b1, b_q[MANT_BITS-1:0]};
  assign ea_x   = {2'b00, ea};
  assign eb_x   = {2'b00, eb};
  assign sa     = a_q[BITS-1];
  assign sb     = b_q[BITS-1];
  assign sbe    = sb ^ (op_q == 2'b11);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (a_q[MANT_BITS-1:0] == '0);
  assign b_inf  = (&eb) && (b_q[MANT_BITS-1:0] == '0);
  assign a_nan  = (&ea) && (a_q[MANT_BITS-1:0] != '0);
  assign b_nan  = (&eb) && (b_q[MANT_BITS-1:0] != '0);
  assign a_big  = (a_q[BITS-2:0] >= b_q[BITS-2:0]);

  // Special-value outcomes that bypass the arithmetic path
  logic            spec_hit;
  logic [BITS-1:0] spec_res;
  logic [4:0]      spec_flags;
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) spec_res = QNAN;
    else if (op_q == 2'b00) begin
      if ((a_zero && b_inf) || (a_inf && b_zero)) begin spec_res = QNAN; spec_flags = F_INV; end
      else if (a_inf || b_inf)   spec_res = f_inf(sa ^ sb);
      else if (a_zero || b_zero) spec_res = f_zero(sa ^ sb);
      else spec_hit = 1'b0;
    end else if (op_q == 2'b01) begin
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin spec_res = QNAN; spec_flags = F_INV; end
      else if (a_inf)  spec_res = f_inf(sa ^ sb);
      else if (b_zero) begin spec_res = f_inf(sa ^ sb); spec_flags = F_DBZ; end
      else if (b_inf || a_zero) spec_res = f_zero(sa ^ sb);
      else spec_hit = 1'b0;
    end else begin
      if (a_inf && b_inf && (sa != sbe)) begin spec_res = QNAN; spec_flags = F_INV; end
      else if (a_inf)             spec_res = f_inf(sa);
      else if (b_inf)             spec_res = f_inf(sbe);
      else if (a_zero && b_zero)  spec_res = f_zero(sa & sbe);
      else if (a_zero)            spec_res = {sbe, b_q[BITS-2:0]};
      else if (b_zero)            spec_res = a_q;
      else spec_hit = 1'b0;
    end
  end

  // Arithmetic helpers: product, division step, alignment, leading zeros, rounding
  logic [2*MANT_BITS+1:0] prod;
  logic                   div_ge;
  logic [MANT_BITS+1:0]   rsub, rnext;
  logic [MANT_BITS+3:0]   full, mask, aligned;
  logic [XW-1:0]          lzc;
  logic [MANT_BITS:0]     mant_r;
  logic                   rnd_up, inexact;
  logic signed [XW-1:0]   exp_r;
  logic [BITS-1:0]        rnd_res;
  logic [4:0]             rnd_flags;
  always_comb begin
    prod    = {{(MANT_BITS+1){1'b0}}, ma_q} * {{(MANT_BITS+1){1'b0}}, mb_q};
    div_ge  = (rem_q >= {1'b0, mb_q});
    rsub    = div_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rnext   = rsub << 1;
    full    = {mb_q, 3'b000};
    mask    = ~({(MANT_BITS+4){1'b1}} << diff_q);
    aligned = (diff_q >= DIFF_LIM) ? {{(MANT_BITS+3){1'b0}}, 1'b1}
                                   : ((full >> diff_q) | {{(MANT_BITS+3){1'b0}}, |(full & mask)});
    lzc = '0;
    for (int i = 0; i < SW - 1; i++) if (sig_q[i]) lzc = XW'(SW - 2 - i);
    inexact = |sig_q[2:0];
    rnd_up  = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    mant_r  = {1'b0, sig_q[MANT_BITS+2:3]} + {{MANT_BITS{1'b0}}, rnd_up};
    exp_r   = exp_q + (mant_r[MANT_BITS] ? ONE_X : '0);
    if (sig_q == '0) begin
      rnd_res = '0; rnd_flags = '0;
    end else if (!exp_r[XW-1] && (exp_r >= EXP_MAX_X)) begin
      rnd_res = f_inf(sign_q); rnd_flags = F_OVF;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      rnd_res = f_zero(sign_q); rnd_flags = F_UNF;
    end else begin
      rnd_res = {sign_q, exp_r[EXP_BITS-1:0], mant_r[MANT_BITS-1:0]};
      rnd_flags = {4'b0000, inexact};
    end
  end

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_start) state_d = S_UNPACK;
      S_UNPACK: if (spec_hit)             state_d = S_DONE;
                else if (op_q == 2'b00)   state_d = S_MULT;
                else if (op_q == 2'b01)   state_d = S_DIV;
                else                      state_d = S_ALIGN;
      S_MULT:   state_d = S_NORM;
      S_DIV:    if (cnt_q == DIV_LAST) state_d = S_NORM;
      S_ALIGN:  state_d = S_ADDSUB;
      S_ADDSUB: state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    out_ready = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath registers, advanced per state
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      a_q <= '0; b_q <= '0; op_q <= '0; sign_q <= 1'b0; eff_sub_q <= 1'b0;
      exp_q <= '0; ma_q <= '0; mb_q <= '0; rem_q <= '0; x_q <= '0; y_q <= '0;
      diff_q <= '0; sig_q <= '0; cnt_q <= '0; out_result <= '0; out_flags <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_start) begin a_q <= in_a; b_q <= in_b; op_q <= in_op; end
        S_UNPACK: begin
          cnt_q <= '0;
          sig_q <= '0;
          if (spec_hit) begin
            out_result <= spec_res;
            out_flags  <= spec_flags;
          end else if (op_q == 2'b00) begin
            sign_q <= sa ^ sb; exp_q <= ea_x + eb_x - BIAS_X; ma_q <= ma; mb_q <= mb;
          end else if (op_q == 2'b01) begin
            // Pre-scale so the quotient always lands in [1,2)
            sign_q <= sa ^ sb; mb_q <= mb;
            if (ma < mb) begin rem_q <= {ma, 1'b0}; exp_q <= ea_x - eb_x + BIAS_M1_X; end
            else         begin rem_q <= {1'b0, ma}; exp_q <= ea_x - eb_x + BIAS_X;    end
          end else begin
            eff_sub_q <= sa ^ sbe;
            if (a_big) begin sign_q <= sa;  exp_q <= ea_x; ma_q <= ma; mb_q <= mb; diff_q <= ea - eb; end
            else       begin sign_q <= sbe; exp_q <= eb_x; ma_q <= mb; mb_q <= ma; diff_q <= eb - ea; end
          end
        end
        S_MULT:   sig_q <= {prod[2*MANT_BITS+1:MANT_BITS], prod[MANT_BITS-1], prod[MANT_BITS-2],
                            |prod[MANT_BITS-3:0]};
        S_DIV: begin
          sig_q <= {1'b0, sig_q[MANT_BITS+2:1], div_ge, |rnext};
          rem_q <= rnext;
          cnt_q <= cnt_q + ONE_C;
        end
        S_ALIGN: begin x_q <= {ma_q, 3'b000}; y_q <= aligned; end
        S_ADDSUB: sig_q <= eff_sub_q ? ({1'b0, x_q} - {1'b0, y_q}) : ({1'b0, x_q} + {1'b0, y_q});
        S_NORM:
          if (sig_q[SW-1]) begin
            sig_q <= {1'b0, sig_q[SW-1:2], |sig_q[1:0]};
            exp_q <= exp_q + ONE_X;
          end else begin
            sig_q <= sig_q << lzc;
            exp_q <= exp_q - lzc;
          end
        S_ROUND: begin out_result <= rnd_res; out_flags <= rnd_flags; end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_float_unit.sv
// tb/tb_float_unit.sv - directed vector bench for float_unit
module tb_float_unit;
  logic        in_clk = 1'b0;
  logic        in_rst, in_start;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        out_ready, out_valid;

  float_unit dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_result(out_result), .out_flags(out_flags),
    .out_ready(out_ready), .out_valid(out_valid)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [4:0] fl, output int lat);
    @(negedge in_clk);
    in_op = op; in_a = a; in_b = b; in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge in_clk); #1;
      lat++;
    end
    res = out_result;
    fl  = out_flags;
  endtask

  logic [31:0] res, held;
  logic [4:0]  fl;
  int          lat, pulses, busy_ready;

  initial begin
    vecs[0]  = '{2'b00, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 5};
    vecs[1]  = '{2'b01, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 30};
    vecs[2]  = '{2'b10, 32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001, 6};
    vecs[3]  = '{2'b11, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'b00000, 6};
    vecs[4]  = '{2'b11, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2};
    vecs[5]  = '{2'b01, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2};
    vecs[6]  = '{2'b00, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 5'b00101, 5};
    vecs[7]  = '{2'b00, 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011, 5};
    vecs[8]  = '{2'b10, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'b00000, 6};
    vecs[9]  = '{2'b11, 32'h40000000, 32'h3F800000, 32'h3F800000, 5'b00000, 6};
    vecs[10] = '{2'b00, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 2};
    vecs[11] = '{2'b00, 32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2};
    vecs[12] = '{2'b01, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2};
    vecs[13] = '{2'b00, 32'h80000000, 32'h3F800000, 32'h80000000, 5'b00000, 2};
    vecs[14] = '{2'b10, 32'h80000000, 32'h80000000, 32'h80000000, 5'b00000, 2};
    vecs[15] = '{2'b10, 32'h80000000, 32'h00000000, 32'h00000000, 5'b00000, 2};
    vecs[16] = '{2'b01, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 30};
    vecs[17] = '{2'b00, 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 5};
    vecs[18] = '{2'b01, 32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 2};
    vecs[19] = '{2'b10, 32'h7F800000, 32'h3F800000, 32'h7F800000, 5'b00000, 2};
    vecs[20] = '{2'b00, 32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000, 5};

    in_rst = 1'b1; in_start = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    repeat (3) @(posedge in_clk);
    #1;
    check("reset ready",  32'(out_ready), 32'd1);
    check("reset valid",  32'(out_valid), 32'd0);
    check("reset result", out_result, 32'h0);
    check("reset flags",  32'(out_flags), 32'h0);
    @(negedge in_clk);
    in_rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, fl, lat);
      check($sformatf("v%0d result", i),  res, vecs[i].res);
      check($sformatf("v%0d flags", i),   32'(fl), 32'(vecs[i].fl));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      @(posedge in_clk); #1;
      check($sformatf("v%0d valid pulse", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d ready back", i),  32'(out_ready), 32'd1);
      check($sformatf("v%0d result held", i), out_result, vecs[i].res);
    end

    // start pulses during a divide must be ignored
    @(negedge in_clk);
    in_op = 2'b01; in_a = 32'h40C00000; in_b = 32'h40000000; in_start = 1'b1;
    @(posedge in_clk); #1;
    lat = 1; busy_ready = 0;
    while (!out_valid && lat < 100) begin
      if (out_ready) busy_ready++;
      @(negedge in_clk);
      in_start = (lat % 3 == 0); in_op = 2'b00; in_a = 32'h3F800000; in_b = 32'h3F800000;
      @(posedge in_clk); #1;
      lat++;
    end
    in_start = 1'b0;
    check("busy div latency", 32'(lat), 32'd30);
    check("busy div result",  out_result, 32'h40400000);
    check("busy ready low",   32'(busy_ready), 32'd0);
    @(posedge in_clk); #1;
    check("busy no restart", 32'(out_ready), 32'd1);

    // reset in Div cycle 10
    @(negedge in_clk);
    in_op = 2'b01; in_a = 32'h3F800000; in_b = 32'h40400000; in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    repeat (10) @(posedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    check("mid-div rst ready",  32'(out_ready), 32'd1);
    check("mid-div rst result", out_result, 32'h0);
    check("mid-div rst flags",  32'(out_flags), 32'h0);
    check("mid-div rst valid",  32'(out_valid), 32'd0);
    @(negedge in_clk);
    in_rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge in_clk); #1;
      if (out_valid) pulses++;
    end
    check("mid-div no valid", 32'(pulses), 32'd0);

    run_op(2'b00, 32'h3FC00000, 32'h40000000, res, fl, lat);
    check("post-rst mul result",  res, 32'h40400000);
    check("post-rst mul flags",   32'(fl), 32'h0);
    check("post-rst mul latency", 32'(lat), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
